ysyx_22040386_hazard_ctrl: RTL and testbench
============================================

Name: ysyx_22040386_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline.
- Generates EX operand forwarding selects, ID register-read bypass and MEM store-data bypass for NUM_SRC source operands.
- Adds load-use stall detection and a per-register scoreboard that tracks in-flight long-latency writes (divider/multiplier).
- Keeps saturating stall-cycle performance counters.

Parameters:
- REG_AW, 5, register address width.
- NUM_REGS, 32, architectural registers tracked; must equal 2**REG_AW.
- NUM_SRC, 2, source operands per instruction (1..3).
- CNT_W, 32, width of each stall counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_flush  in  1  kills the ID and EX instructions this cycle (branch/trap).
- i_id_rs_addr  in  NUM_SRC*REG_AW  ID source addresses; src k is at bits [k*REG_AW +: REG_AW].
- i_id_rs_used  in  NUM_SRC  ID source k actually read.
- i_ex_valid  in  1  EX holds a real instruction.
- i_ex_rs_addr  in  NUM_SRC*REG_AW  EX source addresses.
- i_ex_rd_addr  in  REG_AW  EX destination.
- i_ex_regwrite  in  1  EX writes rd.
- i_ex_memread  in  1  EX is a load.
- i_ex_long  in  1  EX issues a long-latency op.
- i_mem_rd_addr  in  REG_AW  EX/MEM destination.
- i_mem_regwrite  in  1  EX/MEM writes rd; never set for long ops.
- i_mem_memwrite  in  1  EX/MEM is a store.
- i_mem_rs2_addr  in  REG_AW  store-data source.
- i_wb_rd_addr  in  REG_AW  MEM/WB destination.
- i_wb_regwrite  in  1  MEM/WB writes rd.
- i_long_done  in  1  long op result is on the WB write port this cycle.
- i_long_rd_addr  in  REG_AW  destination of the completing long op.
- o_ex_srcfw  out  NUM_SRC*2  per EX source: 2'b10 from EX/MEM, 2'b01 from MEM/WB, 2'b00 from the register file.
- o_id_rdfw  out  NUM_SRC  per ID source: bypass from the WB write data.
- o_mem_sdfw  out  1  store data taken from MEM/WB.
- o_stall  out  1  hold PC and IF/ID.
- o_bubble  out  1  insert NOP into ID/EX.
- o_sb_pending  out  NUM_REGS  scoreboard bits.
- o_state  out  2  registered hazard state.
- o_lu_stall_cnt  out  CNT_W  load-use stall cycles.
- o_sb_stall_cnt  out  CNT_W  scoreboard stall cycles.

Behaviour:
- Forwarding, combinational, per source k; address 0 never matches.
  - Bit1 = ex_rs[k]==mem_rd && mem_regwrite.
  - Bit0 = ex_rs[k]==wb_rd && wb_regwrite && !bit1. EX/MEM has priority, so 2'b11 never occurs.
  - o_id_rdfw[k] = used[k] && id_rs[k]==wb_rd && wb_regwrite.
  - o_mem_sdfw = mem_memwrite && rs2==wb_rd && wb_regwrite.
- Load-use hazard (lu): ex_valid && ex_memread && ex_regwrite && ex_rd!=0 && any used[k] with id_rs[k]==ex_rd.
- Scoreboard hazard (sb): any used[k] with pending[id_rs[k]] set, excluding a register cleared by i_long_done this same cycle (the WB bypass covers it).
- Stall outputs: o_stall = o_bubble = (lu || sb) && !i_flush.
- Scoreboard update, at the clock edge:
  - Set: ex_valid && ex_long && ex_regwrite && ex_rd!=0 && !i_flush sets pending[ex_rd].
  - Clear: i_long_done clears pending[long_rd].
  - Same register set and cleared in one cycle: set wins (the newer op is in flight).
  - pending[0] is always 0.
  - i_long_done to a register that is not pending: no effect.
- FSM, registered, one transition per cycle:
  - States: RUN=0, STALL_LU=1, STALL_SB=2.
  - Next state = STALL_SB if sb, else STALL_LU if lu, else RUN; evaluated with !i_flush, and any flush forces RUN.
  - Priority when both hazards exist: sb over lu.
  - o_state shows the reason for the previous cycle's stall.
- Counters: o_lu_stall_cnt increments on cycles where the next state is STALL_LU; o_sb_stall_cnt likewise for STALL_SB. Both saturate at all-ones.
- Reset, asynchronous: pending = 0, o_state = RUN, both counters = 0. Combinational outputs follow their inputs, masked by the zeroed scoreboard.
- Reset asserted while long ops are in flight discards them; the pipeline owner must also reset the long-latency unit.

Decomposition:
- Shared package (ysyx_22040386_pkg): FW_NONE/FW_WB/FW_MEM encodings, hazard-state encodings, REG_AW default.
- Sub-module ysyx_22040386_scoreboard: pending-bit array with set/clear ports and a lookup port per source, instantiated once.
- Forwarding compare is a generate loop over NUM_SRC.

Test Plan:
- EX/MEM and MEM/WB both write x5, EX rs1=x5 -> o_ex_srcfw[1:0]=2'b10. With mem_regwrite=0 -> 2'b01. With rd=x0 -> 2'b00.
- Load to x7 in EX, ID rs2=x7 used -> o_stall=o_bubble=1 for one cycle, next cycle o_state=1, o_lu_stall_cnt=1. Same case with used[1]=0 -> no stall.
- Long div to x9 issued, ID reads x9 for 6 cycles, i_long_done(x9) on the 6th -> stall for 5 cycles, no stall on the done cycle with o_id_rdfw=1, pending[9] cleared, o_sb_stall_cnt=5.
- Same-cycle i_long_done(x9) and a new long issue to x9 -> pending[9] stays 1. Long issue together with i_flush -> pending unchanged.
- Store in MEM with rs2=x3 while WB writes x3 -> o_mem_sdfw=1. With WB writing x0 -> 0.
- pending[4] set, assert i_rst_n=0 mid-cycle -> pending, counters and o_state clear immediately without a clock edge. With CNT_W=2, force 5 stall cycles -> the counter holds at 3.

Source files
------------

// File: rtl/ysyx_22040386_pkg.sv
// Shared encodings for the hazard/forwarding controller: forwarding selects,
// hazard-state encoding and the default register-address width.
package ysyx_22040386_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FW_NONE = 2'b00;
    localparam logic [1:0] FW_WB   = 2'b01;
    localparam logic [1:0] FW_MEM  = 2'b10;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_STALL_LU = 2'd1,
        HZ_STALL_SB = 2'd2
    } hz_state_e;

endpackage

// File: rtl/ysyx_22040386_scoreboard.sv
// Pending-write bit per architectural register for long-latency ops, with a
// lookup per ID source that ignores a register being retired this cycle.
module ysyx_22040386_scoreboard
    import ysyx_22040386_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int NUM_REGS = 2 ** REG_AW,
    parameter int NUM_SRC  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      set_en,
    input  logic [REG_AW-1:0]         set_addr,
    input  logic                      clr_en,
    input  logic [REG_AW-1:0]         clr_addr,
    input  logic [NUM_SRC*REG_AW-1:0] lookup_addr,
    output logic [NUM_SRC-1:0]        lookup_hit,
    output logic [NUM_REGS-1:0]       pending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Set is applied after clear: a new issue to the same rd is still in flight.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_addr] = 1'b0;
        if (set_en) pending_d[set_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_lookup
        logic [REG_AW-1:0] addr;
        assign addr          = lookup_addr[k*REG_AW +: REG_AW];
        // A register retiring now reaches ID through the WB bypass instead.
        assign lookup_hit[k] = pending_q[addr] && !(clr_en && clr_addr == addr);
    end

    assign pending = pending_q;

endmodule

// File: rtl/ysyx_22040386_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: EX/ID/MEM bypass
// selects, load-use and scoreboard stalls, registered stall reason and counters.
module ysyx_22040386_hazard_ctrl
    import ysyx_22040386_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int NUM_REGS = 32,
    parameter int NUM_SRC  = 2,
    parameter int CNT_W    = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic [NUM_SRC*REG_AW-1:0] i_id_rs_addr,
    input  logic [NUM_SRC-1:0]        i_id_rs_used,
    input  logic                      i_ex_valid,
    input  logic [NUM_SRC*REG_AW-1:0] i_ex_rs_addr,
    input  logic [REG_AW-1:0]         i_ex_rd_addr,
    input  logic                      i_ex_regwrite,
    input  logic                      i_ex_memread,
    input  logic                      i_ex_long,
    input  logic [REG_AW-1:0]         i_mem_rd_addr,
    input  logic                      i_mem_regwrite,
    input  logic                      i_mem_memwrite,
    input  logic [REG_AW-1:0]         i_mem_rs2_addr,
    input  logic [REG_AW-1:0]         i_wb_rd_addr,
    input  logic                      i_wb_regwrite,
    input  logic                      i_long_done,
    input  logic [REG_AW-1:0]         i_long_rd_addr,
    output logic [NUM_SRC*2-1:0]      o_ex_srcfw,
    output logic [NUM_SRC-1:0]        o_id_rdfw,
    output logic                      o_mem_sdfw,
    output logic                      o_stall,
    output logic                      o_bubble,
    output logic [NUM_REGS-1:0]       o_sb_pending,
    output logic [1:0]                o_state,
    output logic [CNT_W-1:0]          o_lu_stall_cnt,
    output logic [CNT_W-1:0]          o_sb_stall_cnt
);

    logic [NUM_SRC-1:0] lu_match;
    logic [NUM_SRC-1:0] sb_hit;
    logic               lu_hazard;
    logic               sb_hazard;
    logic               sb_set;
    hz_state_e          state_q;
    hz_state_e          state_d;
    logic [CNT_W-1:0]   lu_cnt_q;
    logic [CNT_W-1:0]   sb_cnt_q;

    // Register x0 is hardwired to zero, so it never takes part in forwarding.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_AW-1:0] ex_rs;
        logic [REG_AW-1:0] id_rs;
        logic              mem_hit;
        logic              wb_hit;

        assign ex_rs   = i_ex_rs_addr[k*REG_AW +: REG_AW];
        assign id_rs   = i_id_rs_addr[k*REG_AW +: REG_AW];
        assign mem_hit = i_mem_regwrite && (ex_rs != '0) && (ex_rs == i_mem_rd_addr);
        assign wb_hit  = i_wb_regwrite && (ex_rs != '0) && (ex_rs == i_wb_rd_addr) && !mem_hit;

        assign o_ex_srcfw[2*k +: 2] = mem_hit ? FW_MEM : (wb_hit ? FW_WB : FW_NONE);
        assign o_id_rdfw[k] = i_id_rs_used[k] && i_wb_regwrite && (id_rs != '0)
                              && (id_rs == i_wb_rd_addr);
        assign lu_match[k]  = i_id_rs_used[k] && (id_rs == i_ex_rd_addr);
    end

    assign o_mem_sdfw = i_mem_memwrite && i_wb_regwrite && (i_mem_rs2_addr != '0)
                        && (i_mem_rs2_addr == i_wb_rd_addr);

    assign lu_hazard = i_ex_valid && i_ex_memread && i_ex_regwrite
                       && (i_ex_rd_addr != '0) && (|lu_match);
    assign sb_hazard = |(i_id_rs_used & sb_hit);
    assign sb_set    = i_ex_valid && i_ex_long && i_ex_regwrite
                       && (i_ex_rd_addr != '0) && !i_flush;

    assign o_stall  = (lu_hazard || sb_hazard) && !i_flush;
    assign o_bubble = o_stall;

    ysyx_22040386_scoreboard #(
        .REG_AW   (REG_AW),
        .NUM_REGS (NUM_REGS),
        .NUM_SRC  (NUM_SRC)
    ) u_scoreboard (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .set_en      (sb_set),
        .set_addr    (i_ex_rd_addr),
        .clr_en      (i_long_done),
        .clr_addr    (i_long_rd_addr),
        .lookup_addr (i_id_rs_addr),
        .lookup_hit  (sb_hit),
        .pending     (o_sb_pending)
    );

    // Scoreboard stalls outrank load-use; a flush always returns to RUN.
    always_comb begin
        state_d = HZ_RUN;
        if (!i_flush) begin
            if (sb_hazard)      state_d = HZ_STALL_SB;
            else if (lu_hazard) state_d = HZ_STALL_LU;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= HZ_RUN;
            lu_cnt_q <= '0;
            sb_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == HZ_STALL_LU && lu_cnt_q != '1) lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            if (state_d == HZ_STALL_SB && sb_cnt_q != '1) sb_cnt_q <= sb_cnt_q + CNT_W'(1);
        end
    end

    assign o_state        = state_q;
    assign o_lu_stall_cnt = lu_cnt_q;
    assign o_sb_stall_cnt = sb_cnt_q;

endmodule

// File: tb/tb_ysyx_22040386_hazard_ctrl.sv
// Directed and randomized checks of the hazard controller against a
// rule-level model; a second instance with 2-bit counters covers saturation.
module tb_ysyx_22040386_hazard_ctrl;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;
    localparam int NUM_SRC  = 2;
    localparam int W        = 102;

    // clock / reset
    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    logic i_rst_n;

    logic                      i_flush;
    logic [NUM_SRC*REG_AW-1:0] i_id_rs_addr;
    logic [NUM_SRC-1:0]        i_id_rs_used;
    logic                      i_ex_valid;
    logic [NUM_SRC*REG_AW-1:0] i_ex_rs_addr;
    logic [REG_AW-1:0]         i_ex_rd_addr;
    logic                      i_ex_regwrite;
    logic                      i_ex_memread;
    logic                      i_ex_long;
    logic [REG_AW-1:0]         i_mem_rd_addr;
    logic                      i_mem_regwrite;
    logic                      i_mem_memwrite;
    logic [REG_AW-1:0]         i_mem_rs2_addr;
    logic [REG_AW-1:0]         i_wb_rd_addr;
    logic                      i_wb_regwrite;
    logic                      i_long_done;
    logic [REG_AW-1:0]         i_long_rd_addr;

    logic [NUM_SRC*2-1:0] o_ex_srcfw,   sat_ex_srcfw;
    logic [NUM_SRC-1:0]   o_id_rdfw,    sat_id_rdfw;
    logic                 o_mem_sdfw,   sat_mem_sdfw;
    logic                 o_stall,      sat_stall;
    logic                 o_bubble,     sat_bubble;
    logic [NUM_REGS-1:0]  o_sb_pending, sat_sb_pending;
    logic [1:0]           o_state,      sat_state;
    logic [31:0]          o_lu_stall_cnt, o_sb_stall_cnt;
    logic [1:0]           sat_lu_stall_cnt, sat_sb_stall_cnt;

    ysyx_22040386_hazard_ctrl #(
        .REG_AW(REG_AW), .NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .CNT_W(32)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_id_rs_addr(i_id_rs_addr), .i_id_rs_used(i_id_rs_used),
        .i_ex_valid(i_ex_valid), .i_ex_rs_addr(i_ex_rs_addr), .i_ex_rd_addr(i_ex_rd_addr),
        .i_ex_regwrite(i_ex_regwrite), .i_ex_memread(i_ex_memread), .i_ex_long(i_ex_long),
        .i_mem_rd_addr(i_mem_rd_addr), .i_mem_regwrite(i_mem_regwrite),
        .i_mem_memwrite(i_mem_memwrite), .i_mem_rs2_addr(i_mem_rs2_addr),
        .i_wb_rd_addr(i_wb_rd_addr), .i_wb_regwrite(i_wb_regwrite),
        .i_long_done(i_long_done), .i_long_rd_addr(i_long_rd_addr),
        .o_ex_srcfw(o_ex_srcfw), .o_id_rdfw(o_id_rdfw), .o_mem_sdfw(o_mem_sdfw),
        .o_stall(o_stall), .o_bubble(o_bubble), .o_sb_pending(o_sb_pending),
        .o_state(o_state), .o_lu_stall_cnt(o_lu_stall_cnt), .o_sb_stall_cnt(o_sb_stall_cnt)
    );

    ysyx_22040386_hazard_ctrl #(
        .REG_AW(REG_AW), .NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .CNT_W(2)
    ) dut_sat (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_id_rs_addr(i_id_rs_addr), .i_id_rs_used(i_id_rs_used),
        .i_ex_valid(i_ex_valid), .i_ex_rs_addr(i_ex_rs_addr), .i_ex_rd_addr(i_ex_rd_addr),
        .i_ex_regwrite(i_ex_regwrite), .i_ex_memread(i_ex_memread), .i_ex_long(i_ex_long),
        .i_mem_rd_addr(i_mem_rd_addr), .i_mem_regwrite(i_mem_regwrite),
        .i_mem_memwrite(i_mem_memwrite), .i_mem_rs2_addr(i_mem_rs2_addr),
        .i_wb_rd_addr(i_wb_rd_addr), .i_wb_regwrite(i_wb_regwrite),
        .i_long_done(i_long_done), .i_long_rd_addr(i_long_rd_addr),
        .o_ex_srcfw(sat_ex_srcfw), .o_id_rdfw(sat_id_rdfw), .o_mem_sdfw(sat_mem_sdfw),
        .o_stall(sat_stall), .o_bubble(sat_bubble), .o_sb_pending(sat_sb_pending),
        .o_state(sat_state), .o_lu_stall_cnt(sat_lu_stall_cnt), .o_sb_stall_cnt(sat_sb_stall_cnt)
    );

    // scoreboard / reference model
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [31:0]  pend_m, lu_m, sb_m;
    logic [1:0]   st_m, sat_lu_m, sat_sb_m;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] fw_m(input int k);
        logic [4:0] rs;
        rs = i_ex_rs_addr[k*REG_AW +: REG_AW];
        if (rs != 0 && i_mem_regwrite && rs == i_mem_rd_addr) return 2'b10;
        if (rs != 0 && i_wb_regwrite && rs == i_wb_rd_addr) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic rdfw_m(input int k);
        logic [4:0] rs;
        rs = i_id_rs_addr[k*REG_AW +: REG_AW];
        return i_id_rs_used[k] && i_wb_regwrite && rs != 0 && rs == i_wb_rd_addr;
    endfunction

    function automatic logic sdfw_m();
        return i_mem_memwrite && i_wb_regwrite && i_mem_rs2_addr != 0
               && i_mem_rs2_addr == i_wb_rd_addr;
    endfunction

    function automatic logic lu_f();
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++)
            if (i_id_rs_used[k] && i_id_rs_addr[k*REG_AW +: REG_AW] == i_ex_rd_addr) hit = 1'b1;
        return i_ex_valid && i_ex_memread && i_ex_regwrite && i_ex_rd_addr != 0 && hit;
    endfunction

    function automatic logic sb_f();
        logic       hit;
        logic [4:0] rs;
        hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rs = i_id_rs_addr[k*REG_AW +: REG_AW];
            if (i_id_rs_used[k] && pend_m[rs] && !(i_long_done && i_long_rd_addr == rs)) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic model_reset();
        pend_m = '0; lu_m = '0; sb_m = '0; st_m = 2'd0; sat_lu_m = 2'd0; sat_sb_m = 2'd0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [1:0] nxt;
        nxt = i_flush ? 2'd0 : (sb_f() ? 2'd2 : (lu_f() ? 2'd1 : 2'd0));
        if (nxt == 2'd1) begin
            if (lu_m != 32'hFFFF_FFFF) lu_m = lu_m + 1;
            if (sat_lu_m != 2'd3) sat_lu_m = sat_lu_m + 1;
        end
        if (nxt == 2'd2) begin
            if (sb_m != 32'hFFFF_FFFF) sb_m = sb_m + 1;
            if (sat_sb_m != 2'd3) sat_sb_m = sat_sb_m + 1;
        end
        if (i_long_done) pend_m[i_long_rd_addr] = 1'b0;
        if (i_ex_valid && i_ex_long && i_ex_regwrite && i_ex_rd_addr != 0 && !i_flush)
            pend_m[i_ex_rd_addr] = 1'b1;
        pend_m[0] = 1'b0;
        st_m = nxt;
        exp_q.push_back({st_m, lu_m, sb_m, pend_m, sat_lu_m, sat_sb_m});
    endtask

    // driver tasks
    task automatic clear_inputs();
        i_flush = 0; i_id_rs_addr = '0; i_id_rs_used = '0; i_ex_valid = 0; i_ex_rs_addr = '0;
        i_ex_rd_addr = '0; i_ex_regwrite = 0; i_ex_memread = 0; i_ex_long = 0;
        i_mem_rd_addr = '0; i_mem_regwrite = 0; i_mem_memwrite = 0; i_mem_rs2_addr = '0;
        i_wb_rd_addr = '0; i_wb_regwrite = 0; i_long_done = 0; i_long_rd_addr = '0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        i_ex_valid = 1; i_ex_long = 1; i_ex_regwrite = 1; i_ex_rd_addr = rd;
    endtask

    // Called at posedge+1 with inputs applied: checks combinational outputs,
    // advances the model, then checks registered outputs after the edge.
    task automatic cycle();
        logic [W-1:0]         e;
        logic [2*NUM_SRC-1:0] fw_e;
        logic [NUM_SRC-1:0]   rdfw_e;
        logic                 stall_e;
        #3;
        for (int k = 0; k < NUM_SRC; k++) begin
            fw_e[2*k +: 2] = fw_m(k);
            rdfw_e[k]      = rdfw_m(k);
        end
        stall_e = (lu_f() || sb_f()) && !i_flush;
        chk("ex_srcfw", o_ex_srcfw, fw_e);
        chk("id_rdfw", o_id_rdfw, rdfw_e);
        chk("mem_sdfw", o_mem_sdfw, sdfw_m());
        chk("stall", o_stall, stall_e);
        chk("bubble", o_bubble, stall_e);
        chk("sb_pending", o_sb_pending, pend_m);
        chk("sat_comb", {sat_ex_srcfw, sat_id_rdfw, sat_mem_sdfw, sat_stall, sat_bubble, sat_sb_pending},
            {fw_e, rdfw_e, sdfw_m(), stall_e, stall_e, pend_m});
        model_step();
        @(posedge i_clk);
        #1;
        e = exp_q.pop_front();
        chk("state", o_state, e[101:100]);
        chk("lu_cnt", o_lu_stall_cnt, e[99:68]);
        chk("sb_cnt", o_sb_stall_cnt, e[67:36]);
        chk("pending_reg", o_sb_pending, e[35:4]);
        chk("sat_state", sat_state, e[101:100]);
        chk("sat_lu_cnt", sat_lu_stall_cnt, e[3:2]);
        chk("sat_sb_cnt", sat_sb_stall_cnt, e[1:0]);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        i_rst_n = 0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_state", o_state, 2'd0);
        chk("rst_lu_cnt", o_lu_stall_cnt, 32'd0);
        chk("rst_sb_cnt", o_sb_stall_cnt, 32'd0);
        chk("rst_pending", o_sb_pending, 32'd0);
        i_rst_n = 1;

        // forwarding priority and x0
        i_mem_rd_addr = 5; i_mem_regwrite = 1; i_wb_rd_addr = 5; i_wb_regwrite = 1;
        i_ex_rs_addr = {5'd0, 5'd5};
        #2 chk("fw_mem_pri", o_ex_srcfw[1:0], 2'b10);
        cycle();
        i_mem_regwrite = 0;
        #2 chk("fw_wb", o_ex_srcfw[1:0], 2'b01);
        cycle();
        i_mem_regwrite = 1; i_mem_rd_addr = 0; i_wb_rd_addr = 0; i_ex_rs_addr = '0;
        #2 chk("fw_x0", o_ex_srcfw[1:0], 2'b00);
        cycle();

        // load-use on src1
        clear_inputs();
        i_ex_valid = 1; i_ex_memread = 1; i_ex_regwrite = 1; i_ex_rd_addr = 7;
        i_id_rs_addr = {5'd7, 5'd1}; i_id_rs_used = 2'b11;
        #2 chk("lu_stall", {o_stall, o_bubble}, 2'b11);
        cycle();
        chk("lu_state", o_state, 2'd1);
        chk("lu_cnt1", o_lu_stall_cnt, 32'd1);
        clear_inputs();
        cycle();
        i_ex_valid = 1; i_ex_memread = 1; i_ex_regwrite = 1; i_ex_rd_addr = 7;
        i_id_rs_addr = {5'd7, 5'd1}; i_id_rs_used = 2'b01;
        #2 chk("lu_unused", o_stall, 1'b0);
        cycle();

        // long divide to x9, ID waits on it
        clear_inputs();
        issue_long(5'd9);
        cycle();
        clear_inputs();
        i_id_rs_addr = {5'd0, 5'd9}; i_id_rs_used = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #2 chk("sb_stall", o_stall, 1'b1);
            cycle();
        end
        i_long_done = 1; i_long_rd_addr = 9; i_wb_rd_addr = 9; i_wb_regwrite = 1;
        #2 chk("sb_done_nostall", o_stall, 1'b0);
        chk("sb_done_rdfw", o_id_rdfw[0], 1'b1);
        cycle();
        chk("sb_cleared", o_sb_pending[9], 1'b0);
        chk("sb_cnt5", o_sb_stall_cnt, 32'd5);
        chk("sat_hold", sat_sb_stall_cnt, 2'd3);

        // same-cycle set and clear, then flushed issue
        clear_inputs();
        issue_long(5'd9);
        cycle();
        i_long_done = 1; i_long_rd_addr = 9;
        cycle();
        chk("set_wins", o_sb_pending[9], 1'b1);
        clear_inputs();
        i_long_done = 1; i_long_rd_addr = 9;
        cycle();
        clear_inputs();
        issue_long(5'd10); i_flush = 1;
        cycle();
        chk("flush_noset", o_sb_pending, 32'd0);

        // store-data bypass
        clear_inputs();
        i_mem_memwrite = 1; i_mem_rs2_addr = 3; i_wb_rd_addr = 3; i_wb_regwrite = 1;
        #2 chk("sdfw_hit", o_mem_sdfw, 1'b1);
        cycle();
        i_wb_rd_addr = 0;
        #2 chk("sdfw_x0", o_mem_sdfw, 1'b0);
        cycle();

        // asynchronous reset with x4 pending and a stall recorded
        clear_inputs();
        issue_long(5'd4);
        cycle();
        clear_inputs();
        i_id_rs_addr = {5'd0, 5'd4}; i_id_rs_used = 2'b01;
        cycle();
        chk("pre_rst_pend4", o_sb_pending[4], 1'b1);
        #2 i_rst_n = 0;
        #1;
        chk("async_state", o_state, 2'd0);
        chk("async_pending", o_sb_pending, 32'd0);
        chk("async_cnts", {o_lu_stall_cnt, o_sb_stall_cnt}, 64'd0);
        chk("async_sat", {sat_lu_stall_cnt, sat_sb_stall_cnt}, 4'd0);
        model_reset();
        clear_inputs();
        @(posedge i_clk);
        #1 i_rst_n = 1;

        // randomized traffic over a small register window to force collisions
        for (int i = 0; i < 300; i++) begin
            i_flush        = ($urandom_range(0, 7) == 0);
            i_id_rs_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            i_id_rs_used   = 2'($urandom_range(0, 3));
            i_ex_valid     = ($urandom_range(0, 3) != 0);
            i_ex_rs_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            i_ex_rd_addr   = 5'($urandom_range(0, 7));
            i_ex_regwrite  = ($urandom_range(0, 3) != 0);
            i_ex_memread   = ($urandom_range(0, 2) == 0);
            i_ex_long      = ($urandom_range(0, 4) == 0);
            i_mem_rd_addr  = 5'($urandom_range(0, 7));
            i_mem_regwrite = $urandom_range(0, 1) == 1;
            i_mem_memwrite = $urandom_range(0, 1) == 1;
            i_mem_rs2_addr = 5'($urandom_range(0, 7));
            i_wb_rd_addr   = 5'($urandom_range(0, 7));
            i_wb_regwrite  = $urandom_range(0, 1) == 1;
            i_long_done    = ($urandom_range(0, 2) == 0);
            i_long_rd_addr = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
